// File: rtl/rat_checkpoint_ctrl_pkg.sv
// ============================================================================
//  Module      : rat_checkpoint_ctrl_pkg
//  Description : Shared sizes, slot types and FSM encoding for rename checkpoints.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rat_checkpoint_ctrl_pkg;

    localparam int unsigned c_rat_cp_size  = 4;
    localparam int unsigned c_rat_cp_idx_w = $clog2(c_rat_cp_size);

    typedef logic [c_rat_cp_idx_w-1:0] cp_idx_t;
    typedef logic [c_rat_cp_size-1:0]  cp_mask_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } cp_state_e;

endpackage

`default_nettype wire

// File: rtl/rat_checkpoint_ctrl_if.sv
// ============================================================================
//  Module      : rat_checkpoint_ctrl_if
//  Description : Rename-stage checkpoint request/resolution/snapshot bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rat_checkpoint_ctrl_if
    import rat_checkpoint_ctrl_pkg::*;
#(
    parameter int CP_SIZE  = c_rat_cp_size,
    parameter int CP_IDX_W = $clog2(CP_SIZE)
);

    logic                br_req;
    logic                res_valid;
    logic [CP_IDX_W-1:0] res_idx;
    logic                res_mispredict;
    logic                check;
    logic [CP_IDX_W-1:0] check_idx;
    logic                recover;
    logic [CP_IDX_W-1:0] recover_idx;
    logic                cp_stall;
    logic [CP_SIZE-1:0]  live_mask;

    modport master (
        output br_req, res_valid, res_idx, res_mispredict,
        input  check, check_idx, recover, recover_idx, cp_stall, live_mask
    );

    modport slave (
        input  br_req, res_valid, res_idx, res_mispredict,
        output check, check_idx, recover, recover_idx, cp_stall, live_mask
    );

endinterface

`default_nettype wire

// File: rtl/rat_checkpoint_ctrl_cp_squash_mask.sv
// ============================================================================
//  Module      : cp_squash_mask
//  Description : Marks the mispredicted slot and every younger allocated slot.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp_squash_mask
    import rat_checkpoint_ctrl_pkg::*;
#(
    parameter int CP_SIZE  = c_rat_cp_size,
    parameter int CP_IDX_W = $clog2(CP_SIZE)
) (
    input  wire logic [CP_IDX_W-1:0] i_head,
    input  wire logic [CP_IDX_W-1:0] i_res_idx,
    input  wire logic [CP_IDX_W-1:0] i_tail,
    output logic      [CP_SIZE-1:0]  o_mask
);

    logic [CP_IDX_W-1:0] w_d_res;
    logic [CP_IDX_W-1:0] w_d_tail;

    // Ages relative to head; a zero tail distance can only mean "full" here,
    // because a squash always names a live slot.
    assign w_d_res  = i_res_idx - i_head;
    assign w_d_tail = i_tail - i_head;

    for (genvar i = 0; i < CP_SIZE; i++) begin : g_slot
        logic [CP_IDX_W-1:0] w_d_slot;
        assign w_d_slot  = CP_IDX_W'(i) - i_head;
        assign o_mask[i] = (w_d_slot >= w_d_res) &&
                           ((w_d_tail == '0) || (w_d_slot < w_d_tail));
    end

endmodule

`default_nettype wire

// File: rtl/rat_checkpoint_ctrl.sv
// ============================================================================
//  Module      : rat_checkpoint_ctrl
//  Description : Circular allocator of RAT/free-list checkpoints for branches.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rat_checkpoint_ctrl
    import rat_checkpoint_ctrl_pkg::*;
#(
    parameter int CP_SIZE  = c_rat_cp_size,
    parameter int CP_IDX_W = $clog2(CP_SIZE)
) (
    input  wire logic           clock,
    input  wire logic           reset,
    rat_checkpoint_ctrl_if.slave cp
);

    localparam logic [CP_IDX_W:0] c_full = (CP_IDX_W+1)'(CP_SIZE);

    logic [CP_IDX_W-1:0] r_head;
    logic [CP_IDX_W-1:0] r_tail;
    logic [CP_IDX_W:0]   r_count;
    logic [CP_SIZE-1:0]  r_live;
    logic [CP_SIZE-1:0]  r_resolved;
    cp_state_e           r_state;

    cp_state_e           w_state_next;
    logic                w_mis;
    logic                w_ok;
    logic                w_stall;
    logic                w_check;
    logic                w_release;
    logic [CP_SIZE-1:0]  w_squash;

    cp_squash_mask #(
        .CP_SIZE  (CP_SIZE),
        .CP_IDX_W (CP_IDX_W)
    ) u_squash (
        .i_head    (r_head),
        .i_res_idx (cp.res_idx),
        .i_tail    (r_tail),
        .o_mask    (w_squash)
    );

    // Reset masks the combinational strobes so a discarded slot never recovers.
    always_comb begin
        w_state_next = ST_IDLE;
        w_mis        = 1'b0;
        w_ok         = 1'b0;
        w_stall      = 1'b0;
        w_check      = 1'b0;
        w_release    = 1'b0;

        w_mis   = ~reset & cp.res_valid &  cp.res_mispredict & r_live[cp.res_idx];
        w_ok    = ~reset & cp.res_valid & ~cp.res_mispredict & r_live[cp.res_idx];
        w_stall = (r_count == c_full) | (r_state == ST_RECOVER) | w_mis;
        w_check = ~reset & cp.br_req & ~w_stall;
        w_release = ~w_mis & r_live[r_head] &
                    (r_resolved[r_head] | (w_ok & (cp.res_idx == r_head)));

        case (r_state)
            ST_IDLE:    w_state_next = w_mis ? ST_RECOVER : ST_IDLE;
            ST_RECOVER: w_state_next = w_mis ? ST_RECOVER : ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    assign cp.check       = w_check;
    assign cp.check_idx   = r_tail;
    assign cp.recover     = w_mis;
    assign cp.recover_idx = cp.res_idx;
    assign cp.cp_stall    = w_stall;
    assign cp.live_mask   = r_live;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_live     <= '0;
            r_resolved <= '0;
            r_state    <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
            if (w_mis) begin
                r_live     <= r_live & ~w_squash;
                r_resolved <= r_resolved & ~w_squash;
                r_tail     <= cp.res_idx;
                r_count    <= {1'b0, cp.res_idx - r_head};
            end else begin
                if (w_ok) begin
                    r_resolved[cp.res_idx] <= 1'b1;
                end
                // Allocation and release never target the same slot: tail==head
                // only when empty (no release) or full (no allocation).
                if (w_check) begin
                    r_live[r_tail]     <= 1'b1;
                    r_resolved[r_tail] <= 1'b0;
                    r_tail             <= r_tail + 1'b1;
                end
                if (w_release) begin
                    r_live[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                end
                r_count <= r_count + {{CP_IDX_W{1'b0}}, w_check}
                                   - {{CP_IDX_W{1'b0}}, w_release};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rat_checkpoint_ctrl.sv
// ============================================================================
//  Module      : tb_rat_checkpoint_ctrl
//  Description : Directed vector bench for the rename checkpoint controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rat_checkpoint_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rat_checkpoint_ctrl_if #(.CP_SIZE(4), .CP_IDX_W(2)) bus ();

    rat_checkpoint_ctrl #(
        .CP_SIZE  (4),
        .CP_IDX_W (2)
    ) dut (
        .clock (clk),
        .reset (rst),
        .cp    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       br;
        logic       rv;
        logic [1:0] idx;
        logic       mis;
        logic       e_chk;
        logic [1:0] e_cidx;
        logic       e_rec;
        logic       e_stall;
        logic [3:0] e_live;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic r, input logic b, input logic v,
                                input logic [1:0] i, input logic m,
                                input logic ec, input logic [1:0] eci,
                                input logic er, input logic es, input logic [3:0] el);
        vt.push_back('{r, b, v, i, m, ec, eci, er, es, el});
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Called just after a posedge: drive, check comb outputs, clock, check live_mask.
    task automatic step(input string tag, input vec_t v);
        rst                = v.rst;
        bus.br_req         = v.br;
        bus.res_valid      = v.rv;
        bus.res_idx        = v.idx;
        bus.res_mispredict = v.mis;
        #2;
        chk({tag, " check"},       {3'b0, bus.check},    {3'b0, v.e_chk});
        chk({tag, " check_idx"},   {2'b0, bus.check_idx}, {2'b0, v.e_cidx});
        chk({tag, " recover"},     {3'b0, bus.recover},  {3'b0, v.e_rec});
        if (v.e_rec)
            chk({tag, " recover_idx"}, {2'b0, bus.recover_idx}, {2'b0, v.idx});
        chk({tag, " cp_stall"},    {3'b0, bus.cp_stall}, {3'b0, v.e_stall});
        @(posedge clk);
        #1;
        chk({tag, " live_mask"},   bus.live_mask,        v.e_live);
    endtask

    // Shorthands for the hand-written sequences.
    task automatic s(input string tag, input logic r, input logic b, input logic v,
                     input logic [1:0] i, input logic m, input logic ec,
                     input logic [1:0] eci, input logic er, input logic es,
                     input logic [3:0] el);
        step(tag, '{r, b, v, i, m, ec, eci, er, es, el});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.br_req = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_idx = 2'd0;
        bus.res_mispredict = 1'b0;

        //   rst br rv idx mis | chk cidx rec stall live
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000); // reset state
        add(0, 1, 0, 0, 0,  1, 0, 0, 0, 4'b0001);
        add(0, 1, 0, 0, 0,  1, 1, 0, 0, 4'b0011);
        add(0, 1, 0, 0, 0,  1, 2, 0, 0, 4'b0111);
        add(0, 1, 0, 0, 0,  1, 3, 0, 0, 4'b1111);
        add(0, 1, 0, 0, 0,  0, 0, 0, 1, 4'b1111); // full stall
        add(0, 0, 1, 0, 0,  0, 0, 0, 1, 4'b1110); // ok head, no bypass
        add(0, 1, 0, 0, 0,  1, 0, 0, 0, 4'b1111); // wrap alloc idx 0
        add(1, 0, 0, 0, 0,  0, 1, 0, 1, 4'b0000);
        add(0, 1, 0, 0, 0,  1, 0, 0, 0, 4'b0001);
        add(0, 1, 0, 0, 0,  1, 1, 0, 0, 4'b0011);
        add(0, 1, 0, 0, 0,  1, 2, 0, 0, 4'b0111);
        add(0, 1, 0, 0, 0,  1, 3, 0, 0, 4'b1111);
        add(0, 0, 1, 2, 0,  0, 0, 0, 1, 4'b1111); // ok out of order
        add(0, 0, 1, 1, 0,  0, 0, 0, 1, 4'b1111);
        add(0, 0, 1, 0, 0,  0, 0, 0, 1, 4'b1110); // in-order release chain
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1100);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1000);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1000);
        add(1, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000);
        add(0, 1, 0, 0, 0,  1, 0, 0, 0, 4'b0001);
        add(0, 1, 0, 0, 0,  1, 1, 0, 0, 4'b0011);
        add(0, 1, 0, 0, 0,  1, 2, 0, 0, 4'b0111);
        add(0, 1, 0, 0, 0,  1, 3, 0, 0, 4'b1111);
        add(0, 1, 1, 1, 1,  0, 0, 1, 1, 4'b0001); // mis beats br_req
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 4'b0001); // RECOVER cycle
        add(0, 1, 0, 0, 0,  1, 1, 0, 0, 4'b0011);

        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < vt.size(); n++)
            step($sformatf("vec%0d", n), vt[n]);

        // Wrapped squash: head=3, slots 3,0,1 live, mispredict on slot 0.
        s("w_rst", 1, 0, 0, 0, 0,  0, 2, 0, 0, 4'b0000);
        s("w_a0",  0, 1, 0, 0, 0,  1, 0, 0, 0, 4'b0001);
        s("w_a1",  0, 1, 0, 0, 0,  1, 1, 0, 0, 4'b0011);
        s("w_a2",  0, 1, 0, 0, 0,  1, 2, 0, 0, 4'b0111);
        s("w_r0",  0, 0, 1, 0, 0,  0, 3, 0, 0, 4'b0110);
        s("w_r1",  0, 0, 1, 1, 0,  0, 3, 0, 0, 4'b0100);
        s("w_r2",  0, 0, 1, 2, 0,  0, 3, 0, 0, 4'b0000);
        s("w_a3",  0, 1, 0, 0, 0,  1, 3, 0, 0, 4'b1000);
        s("w_a4",  0, 1, 0, 0, 0,  1, 0, 0, 0, 4'b1001);
        s("w_a5",  0, 1, 0, 0, 0,  1, 1, 0, 0, 4'b1011);
        s("w_mis", 0, 1, 1, 0, 1,  0, 2, 1, 1, 4'b1000);
        s("w_sok", 0, 0, 1, 1, 0,  0, 0, 0, 1, 4'b1000);
        s("w_smi", 0, 0, 1, 1, 1,  0, 0, 0, 0, 4'b1000);
        s("w_b0",  0, 1, 0, 0, 0,  1, 0, 0, 0, 4'b1001);
        s("w_b1",  0, 1, 0, 0, 0,  1, 1, 0, 0, 4'b1011);
        s("w_b2",  0, 1, 0, 0, 0,  1, 2, 0, 0, 4'b1111);
        s("w_full",0, 1, 0, 0, 0,  0, 3, 0, 1, 4'b1111);

        // Reset wins over a pending mispredict.
        s("r_rst", 1, 0, 0, 0, 0,  0, 3, 0, 1, 4'b0000);
        s("r_a0",  0, 1, 0, 0, 0,  1, 0, 0, 0, 4'b0001);
        s("r_a1",  0, 1, 0, 0, 0,  1, 1, 0, 0, 4'b0011);
        s("r_a2",  0, 1, 0, 0, 0,  1, 2, 0, 0, 4'b0111);
        s("r_mis", 1, 0, 1, 1, 1,  0, 3, 0, 0, 4'b0000);
        s("r_a",   0, 1, 0, 0, 0,  1, 0, 0, 0, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
